// File: rtl/fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit
//
// Front end of the 8-bit CSE141L core. This block owns the program counter,
// addresses a synchronous instruction ROM, and decodes the 9-bit word the ROM
// returns. Each instruction takes two cycles:
//   FETCH  : the address goes out on o_imemAddr and the ROM registers the word.
//   DECODE : the word is decoded combinationally. The write enables pulse
//            for this one cycle, and the pc is updated on the closing edge.
// A HALT instruction moves the block to HALTED. It stays there until reset.
//
// Optional feature (compile-time macro FETCH_STALL_EN):
//   This macro adds the i_stall input. While i_stall is high in FETCH or
//   DECODE, the state and pc hold and every write enable is forced low. In
//   DECODE the decode fields stay visible, but o_instrValid drops.
//   Reset overrides stall.
//
// Ports:
//   i_clock          core clock, all state changes on posedge
//   i_reset          synchronous active-high reset
//   i_stall          (FETCH_STALL_EN only) hold the pipeline in place
//   o_imemAddr       instruction ROM address (always equals pc)
//   i_imemData       ROM data, valid one cycle after the address
//   i_branchTaken    branch condition, used only in DECODE of a BR
//   i_branchTarget   branch destination, sampled with i_branchTaken
//   o_readRegister1  instr[5:3], destination / first source
//   o_readRegister2  instr[2:0], second source
//   o_ltIndex        instr[2:0], lookup-table index (MOVI, BR)
//   o_immediate      MOVI: second operand comes from the lookup table
//   o_regWrite       register file write enable
//   o_memWrite       data memory write enable
//   o_aluOp          instr[8:6], passed through to the ALU
//   o_instrValid     high while a decoded instruction is presented
//   o_pcOut          current pc, for trace
//   o_done           program finished (HALTED)
// ---------------------------------------------------------------------------
module fetch_decode_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
) (
  input  logic               i_clock,
  input  logic               i_reset,
`ifdef FETCH_STALL_EN
  input  logic               i_stall,
`endif
  output logic [PC_W-1:0]    o_imemAddr,
  input  logic [INSTR_W-1:0] i_imemData,
  input  logic               i_branchTaken,
  input  logic [PC_W-1:0]    i_branchTarget,
  output logic [2:0]         o_readRegister1,
  output logic [2:0]         o_readRegister2,
  output logic [2:0]         o_ltIndex,
  output logic               o_immediate,
  output logic               o_regWrite,
  output logic               o_memWrite,
  output logic [2:0]         o_aluOp,
  output logic               o_instrValid,
  output logic [PC_W-1:0]    o_pcOut,
  output logic               o_done
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_MOVI  = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [2:0] OP_BR    = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic            w_stall;
  logic [2:0]      w_opcode;
  logic [2:0]      w_enables;

  // Per-opcode enables, packed as {regWrite, memWrite, immediate}.
  function automatic logic [2:0] f_decode_enables(input logic [2:0] opcode);
    logic [2:0] en;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_LOAD: en = 3'b100;
      OP_MOVI:                         en = 3'b101;
      OP_STORE:                        en = 3'b010;
      OP_BR, OP_HALT:                  en = 3'b000;
      default:                         en = 3'b000;
    endcase
    return en;
  endfunction

`ifdef FETCH_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_opcode   = i_imemData[8:6];
  assign w_enables  = f_decode_enables(w_opcode);
  // The ROM is addressed straight from pc, so it re-delivers the same word
  // while the block holds in DECODE.
  assign o_imemAddr = r_pc;
  assign o_pcOut    = r_pc;

  // State and program counter registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_FETCH;
      r_pc    <= {PC_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // Next-state, next-pc and decode outputs for the fetch/decode loop.
  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    o_readRegister1 = 3'd0;
    o_readRegister2 = 3'd0;
    o_ltIndex       = 3'd0;
    o_immediate     = 1'b0;
    o_regWrite      = 1'b0;
    o_memWrite      = 1'b0;
    o_aluOp         = 3'd0;
    o_instrValid    = 1'b0;
    o_done          = 1'b0;

    // During reset all outputs stay low. This covers an edge that lands in
    // the middle of a DECODE, so no write commits on that edge.
    if (i_reset) begin
      w_next_state = ST_FETCH;
      w_next_pc    = {PC_W{1'b0}};
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_stall) begin
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_DECODE;
          end
        end

        ST_DECODE: begin
          o_readRegister1 = i_imemData[5:3];
          o_readRegister2 = i_imemData[2:0];
          o_ltIndex       = i_imemData[2:0];
          o_aluOp         = w_opcode;
          if (w_stall) begin
            // The fields stay visible, but nothing commits and pc holds.
            w_next_state = ST_DECODE;
          end else begin
            o_instrValid = 1'b1;
            o_regWrite   = w_enables[2];
            o_memWrite   = w_enables[1];
            o_immediate  = w_enables[0];
            if (w_opcode == OP_HALT) begin
              w_next_state = ST_HALTED;
            end else if ((w_opcode == OP_BR) && i_branchTaken) begin
              w_next_state = ST_FETCH;
              w_next_pc    = i_branchTarget;
            end else begin
              w_next_state = ST_FETCH;
              w_next_pc    = r_pc + PC_ONE;
            end
          end
        end

        ST_HALTED: begin
          o_done       = 1'b1;
          w_next_state = ST_HALTED;
        end

        default: begin
          w_next_state = ST_FETCH;
          w_next_pc    = {PC_W{1'b0}};
        end
      endcase
    end
  end

endmodule
